// File: rtl/timer_counter_core.sv
// -----------------------------------------------------------------------------
// timer_counter_core
//
// Counting stage of the 8-bit timer. It takes the timer-control fields produced
// by the APB register controller and runs a prescaled up/down counter, then
// hands back single-cycle overflow/underflow pulses that the controller latches
// into its status register.
//
// Everything runs on clk. The prescaler produces a one-cycle count enable
// (tick); it never creates a derived clock.
//
// Ports
//   clk            in   system clock, rising-edge active
//   rst_n          in   asynchronous, active-low reset
//   start_counter  in   WIDTH  value forced into the counter while load=1
//   load           in   level, highest priority: counter <= start_counter
//   up_down        in   0 = count up, 1 = count down
//   enable         in   level, counting permitted
//   clk_sel        in   2  tick divisor: 00 /2, 01 /4, 10 /8, 11 /16
//   tcnt           out  WIDTH  current counter value
//   tick           out  combinational count-enable strobe (observability)
//   overflow       out  one-clk pulse when an up-count wraps max -> 0
//   underflow      out  one-clk pulse when a down-count wraps 0 -> max
//   state_dbg      out  current FSM state, 0 = STOP, 1 = COUNT
//
// Handshake: there is no valid/ready pair. Inputs are levels sampled on every
// rising edge; outputs are valid every cycle, and overflow/underflow are
// high for exactly the one cycle in which tcnt shows the wrapped value.
// -----------------------------------------------------------------------------
module timer_counter_core #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] start_counter,
  input  logic             load,
  input  logic             up_down,
  input  logic             enable,
  input  logic [1:0]       clk_sel,
  output logic [WIDTH-1:0] tcnt,
  output logic             tick,
  output logic             overflow,
  output logic             underflow,
  output logic             state_dbg
);

  typedef enum logic {
    ST_STOP  = 1'b0,
    ST_COUNT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] presc_max;
  logic [1:0]         sel_q;
  logic               sel_chg;
  logic               tick_w;
  logic [WIDTH-1:0]   tcnt_q, tcnt_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;

  // Terminal prescaler value is DIV-1 with DIV = 2 << clk_sel (2, 4, 8, 16).
  assign presc_max = PRESC_W'((32'd2 << clk_sel) - 32'd1);

  // A divisor change restarts the period so no shortened period can tick.
  assign sel_chg = (clk_sel != sel_q);

  assign tick_w = (state_q == ST_COUNT) & ~load & ~sel_chg & (presc_q == presc_max);

  // ---------------------------------------------------------------------------
  // FSM: STOP <-> COUNT. load keeps/forces STOP so that releasing load always
  // starts a fresh, full prescaler period.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOP: begin
        if (enable && !load) state_d = ST_COUNT;
      end
      ST_COUNT: begin
        if (!enable || load) state_d = ST_STOP;
      end
      default: state_d = ST_STOP;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Prescaler next state.
  // ---------------------------------------------------------------------------
  always_comb begin
    presc_d = presc_q;
    if ((state_q != ST_COUNT) || load || sel_chg) begin
      presc_d = '0;
    end else if (presc_q == presc_max) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PRESC_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Counter and wrap flags. load beats tick; flags are computed from the
  // pre-edge count so they line up with the cycle showing the wrapped value.
  // ---------------------------------------------------------------------------
  always_comb begin
    tcnt_d = tcnt_q;
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    if (load) begin
      tcnt_d = start_counter;
    end else if (tick_w) begin
      if (!up_down) begin
        tcnt_d = tcnt_q + WIDTH'(1);
        ovf_d  = (tcnt_q == {WIDTH{1'b1}});
      end else begin
        tcnt_d = tcnt_q - WIDTH'(1);
        unf_d  = (tcnt_q == '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_STOP;
      presc_q <= '0;
      sel_q   <= 2'b00;
      tcnt_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      sel_q   <= clk_sel;
      tcnt_q  <= tcnt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign tcnt      = tcnt_q;
  assign tick      = tick_w;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_timer_counter_core.sv
// -----------------------------------------------------------------------------
// tb_timer_counter_core
//
// Driver tasks apply one input vector per clock (changed on the falling edge)
// and push the expected response, computed by a cycle-level behavioural model,
// into exp_q. A separate monitor samples the DUT each cycle and pops/compares.
// -----------------------------------------------------------------------------
module tb_timer_counter_core;
  localparam int W   = 8;
  localparam int MOD = 1 << W;

  // ---------------------------------------------------------------- clk/reset
  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] start_counter;
  logic         load;
  logic         up_down;
  logic         enable;
  logic [1:0]   clk_sel;
  logic [W-1:0] tcnt;
  logic         tick;
  logic         overflow;
  logic         underflow;
  logic         state_dbg;

  always #5 clk = ~clk;

  timer_counter_core #(.WIDTH(W), .PRESC_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_counter (start_counter),
    .load          (load),
    .up_down       (up_down),
    .enable        (enable),
    .clk_sel       (clk_sel),
    .tcnt          (tcnt),
    .tick          (tick),
    .overflow      (overflow),
    .underflow     (underflow),
    .state_dbg     (state_dbg)
  );

  int n_vec = 0;
  int n_err = 0;

  // expected record: {running, tick (pre-edge), overflow, underflow, tcnt}
  logic [W+3:0] exp_q[$];

  // ------------------------------------------------------- reference model
  // m_run   : counting permitted after the last edge
  // m_phase : clocks elapsed in the current prescaler period
  int         m_tcnt;
  bit         m_run;
  int         m_phase;
  logic [1:0] m_sel;

  task automatic model_reset();
    m_tcnt  = 0;
    m_run   = 1'b0;
    m_phase = 0;
    m_sel   = 2'b00;
  endtask

  // ------------------------------------------------------------- driver
  task automatic cycle(input logic ld, input logic en, input logic ud,
                       input logic [1:0] sel, input logic [W-1:0] sv);
    int div;
    bit chg, tk, ovf, unf;
    logic [W-1:0] t8;
    @(negedge clk);
    load = ld; enable = en; up_down = ud; clk_sel = sel; start_counter = sv;
    div = 2 << sel;
    chg = (sel != m_sel);
    tk  = m_run && !ld && !chg && (m_phase + 1 == div);
    ovf = tk && !ud && (m_tcnt == MOD - 1);
    unf = tk && ud && (m_tcnt == 0);
    if (ld)      m_tcnt = int'(sv);
    else if (tk) m_tcnt = ud ? (m_tcnt + MOD - 1) % MOD : (m_tcnt + 1) % MOD;
    if (!m_run || ld || chg || tk) m_phase = 0;
    else                           m_phase = m_phase + 1;
    m_run = en && !ld;
    m_sel = sel;
    t8 = W'(m_tcnt);
    exp_q.push_back({m_run, tk, ovf, unf, t8});
  endtask

  task automatic run(input int n, input logic en, input logic ud, input logic [1:0] sel);
    for (int i = 0; i < n; i++) cycle(1'b0, en, ud, sel, '0);
  endtask

  // Reset asserted between edges; outputs must clear without waiting for clk.
  task automatic async_reset();
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_vec++;
    if (tcnt !== '0 || overflow !== 1'b0 || underflow !== 1'b0 || state_dbg !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset got tcnt=%h ovf=%b unf=%b st=%b exp 00 0 0 0",
               tcnt, overflow, underflow, state_dbg);
    end
    @(negedge clk);
    #3 rst_n = 1'b1;
    model_reset();
  endtask

  // ------------------------------------------------------------ monitor
  initial begin : monitor
    logic [W+3:0] e;
    logic         tick_s;
    forever begin
      @(negedge clk);
      #2 tick_s = tick;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (tick_s !== e[W+2]) begin
          n_err++;
          $display("FAIL tick t=%0t got %b exp %b", $time, tick_s, e[W+2]);
        end
        if (tcnt !== e[W-1:0]) begin
          n_err++;
          $display("FAIL tcnt t=%0t got %h exp %h", $time, tcnt, e[W-1:0]);
        end
        if (overflow !== e[W+1]) begin
          n_err++;
          $display("FAIL overflow t=%0t got %b exp %b", $time, overflow, e[W+1]);
        end
        if (underflow !== e[W]) begin
          n_err++;
          $display("FAIL underflow t=%0t got %b exp %b", $time, underflow, e[W]);
        end
        if (state_dbg !== e[W+3]) begin
          n_err++;
          $display("FAIL state t=%0t got %b exp %b", $time, state_dbg, e[W+3]);
        end
      end
    end
  end

  // ----------------------------------------------------------- stimulus
  initial begin : stim
    logic [1:0] rsel;
    rst_n = 1'b0; load = 1'b0; enable = 1'b0; up_down = 1'b0;
    clk_sel = 2'b00; start_counter = '0;
    model_reset();
    #1;
    n_vec++;
    if (tcnt !== '0 || overflow !== 1'b0 || underflow !== 1'b0 || tick !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state got tcnt=%h ovf=%b unf=%b tick=%b exp 00 0 0 0",
               tcnt, overflow, underflow, tick);
    end
    @(negedge clk);
    #3 rst_n = 1'b1;

    // up wrap FD -> FE -> FF -> 00 at /2
    cycle(1'b1, 1'b0, 1'b0, 2'b00, 8'hFD);
    run(12, 1'b1, 1'b0, 2'b00);

    // down wrap 02 -> 01 -> 00 -> FF at /4
    cycle(1'b1, 1'b0, 1'b1, 2'b01, 8'h02);
    run(18, 1'b1, 1'b1, 2'b01);

    // divisor sweep /8 then /16, with a mid-period change
    cycle(1'b1, 1'b0, 1'b0, 2'b10, 8'h00);
    run(30, 1'b1, 1'b0, 2'b10);
    run(37, 1'b1, 1'b0, 2'b11);
    run(5,  1'b1, 1'b0, 2'b10);
    run(40, 1'b1, 1'b0, 2'b11);

    // load priority: held load with enable, then release to overflow
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, 1'b0, 2'b00, 8'hFF);
    run(6, 1'b1, 1'b0, 2'b00);

    // pause at 0x10, then resume counting down
    cycle(1'b1, 1'b0, 1'b0, 2'b00, 8'h0F);
    run(3,  1'b1, 1'b0, 2'b00);
    run(10, 1'b0, 1'b0, 2'b00);
    run(8,  1'b1, 1'b1, 2'b00);

    // async reset while counting at 0x7A
    cycle(1'b1, 1'b0, 1'b0, 2'b00, 8'h78);
    run(5, 1'b1, 1'b0, 2'b00);
    async_reset();
    run(6, 1'b0, 1'b0, 2'b00);
    run(6, 1'b1, 1'b0, 2'b00);

    // randomized traffic
    rsel = 2'b00;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 29) == 0) rsel = 2'($urandom_range(0, 3));
      cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) != 0),
            1'($urandom_range(0, 1)), rsel, W'($urandom_range(0, MOD - 1)));
    end

    repeat (3) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/timer_counter_core.md
Name: timer_counter_core

Overview:
- Counting stage of the 8-bit timer, directly downstream of the APB register controller.
- Consumes the controller's timer-control outputs (start value, load, up_down, enable, clk_sel) and runs a prescaled up/down counter.
- Returns single-cycle overflow/underflow pulses that the controller captures into its status register.
- Single clock domain: the prescaler generates an internal tick enable, never a derived clock.

Parameters:
- WIDTH, 8, counter and start-value width in bits.
- PRESC_W, 4, prescaler counter width; must hold the largest divisor minus 1 (15).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start_counter  input  WIDTH  value loaded into the counter while load=1.
- load  input  1  level: force the counter to start_counter; highest priority.
- up_down  input  1  0 = count up, 1 = count down.
- enable  input  1  level: counting permitted.
- clk_sel  input  2  tick divisor select: 00 = /2, 01 = /4, 10 = /8, 11 = /16.
- tcnt  output  WIDTH  current counter value.
- tick  output  1  combinational count-enable strobe (observability only).
- overflow  output  1  one-clk pulse on an up-count wrap from max to 0.
- underflow  output  1  one-clk pulse on a down-count wrap from 0 to max.

Behaviour:
- Reset (async, rst_n=0): tcnt=0, presc=0, sel_q=0, state=STOP, overflow=0, underflow=0. All outputs stay low or zero until the first clk edge after rst_n deasserts.
- FSM states and transitions:
  - STOP (reset state) -> COUNT when enable=1 and load=0.
  - COUNT -> STOP when enable=0 or load=1.
  - LOAD is not a separate state. load=1 forces STOP behaviour, and on that edge tcnt <= start_counter.
- Divisor: DIV = 2 << clk_sel, giving 2, 4, 8 or 16.
- sel_q registers clk_sel every cycle. sel_chg = (clk_sel != sel_q).
- Prescaler:
  - Cleared to 0 when any of these hold: state≠COUNT, load=1, or sel_chg=1.
  - Otherwise presc <= (presc == DIV-1) ? 0 : presc+1.
- tick = (state==COUNT) & ~load & ~sel_chg & (presc == DIV-1), combinational.
- Counter update priority, evaluated each edge in this order:
  1. load=1 -> tcnt <= start_counter. No flag is raised, and load wins over simultaneous enable or tick.
  2. tick=1 and up_down=0 -> tcnt <= tcnt+1, modulo 2^WIDTH.
  3. tick=1 and up_down=1 -> tcnt <= tcnt-1, modulo 2^WIDTH.
  4. Otherwise tcnt holds.
- Flags:
  - overflow <= tick & ~up_down & (tcnt == {WIDTH{1}}).
  - underflow <= tick & up_down & (tcnt == 0).
  - Both are registered on the same edge as the wrap, so each is high for exactly the one clk in which tcnt shows the wrapped value, then cleared.
  - They are mutually exclusive and never sticky; stickiness belongs to the controller.
- Latency: the first count occurs DIV clk edges after the first edge at which COUNT is entered with load=0. Thereafter there is one count every DIV clks.
- up_down change mid-period: no prescaler reset; the new direction applies at the next tick.
- clk_sel change: the prescaler restarts, so the next tick comes DIV_new clks after the change edge and no partial-period tick is produced.
- Enable deasserted: tcnt holds its value. Re-enabling restarts the prescaler from 0.
- Reset mid-count: immediate async clear of everything, and no flag pulse.

Test Plan:
- Up wrap: load 0xFD (load=1 for 1 clk), then enable=1, up_down=0, clk_sel=00 -> tcnt goes FD, FE, FF, 00 with 2 clks between steps; overflow=1 only in the cycle tcnt=00; underflow stays 0.
- Down wrap: load 0x02, enable=1, up_down=1, clk_sel=01 -> tcnt goes 02, 01, 00, FF every 4 clks; underflow=1 for exactly 1 clk when tcnt=FF.
- Divisor sweep: clk_sel=10 then 11 from a loaded 0x00 counting up -> steps spaced 8 and 16 clks; changing clk_sel mid-period delays the next step by a full 16 clks.
- Load priority: hold load=1 with enable=1, start_counter=0xFF, up_down=0 for 40 clks -> tcnt stays 0xFF, tick=0, no overflow. Release load -> first step to 0x00 after DIV clks, with an overflow pulse.
- Pause and direction: counting up at 0x10, drop enable for 10 clks -> tcnt holds 0x10. Re-enable with up_down=1 -> the next step is 0x0F, DIV clks later.
- Async reset: assert rst_n=0 between clk edges mid-count at 0x7A -> tcnt=0 and flags=0 immediately; after release, the counter stays at 0 until enabled.
